// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: default widths, opcodes,
// instruction field positions and FSM states.
package alu_pkg;

    localparam int ALU_DATA_W  = 8;
    localparam int ALU_REG_AW  = 2;
    localparam int ALU_INSTR_W = 2 + 3*ALU_REG_AW + ALU_DATA_W;

    // Instruction layout, LSB first: imm | rs2 | rs1 | rd | op
    localparam int IMM_LSB = 0;
    localparam int RS2_LSB = IMM_LSB + ALU_DATA_W;
    localparam int RS1_LSB = RS2_LSB + ALU_REG_AW;
    localparam int RD_LSB  = RS1_LSB + ALU_REG_AW;
    localparam int OP_LSB  = RD_LSB + ALU_REG_AW;

    typedef enum logic [1:0] {
        OP_XOR  = 2'b00,
        OP_ADD  = 2'b01,
        OP_NAND = 2'b10,
        OP_LDI  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Small flop-based register file: two combinational read ports,
// one synchronous write port, synchronous clear.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    localparam int DEPTH = 1 << REG_AW;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage update: clear everything on reset, otherwise single write.
    // NOTE: this array is a handful of flops, so clearing it on reset is cheap;
    // a RAM macro could not be cleared this way and would need a sweep instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Control stage in front of the combinational ALU: accepts an instruction,
// drives the ALU from the register file, writes the result back and offers
// it downstream. One instruction in flight; IDLE -> EXEC -> RESP.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter  int DATA_W  = ALU_DATA_W,
    parameter  int REG_AW  = ALU_REG_AW,
    localparam int INSTR_W = 2 + 3*REG_AW + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [1:0]         alu_opcode,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic [REG_AW-1:0]  res_rd,
    output logic               busy
);

    localparam int F_RS2 = DATA_W;
    localparam int F_RS1 = F_RS2 + REG_AW;
    localparam int F_RD  = F_RS1 + REG_AW;
    localparam int F_OP  = F_RD + REG_AW;

    state_e            r_state;
    state_e            w_next_state;
    op_e               r_op;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_imm;
    logic [1:0]        r_alu_opcode;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [DATA_W-1:0] r_res_data;
    logic [REG_AW-1:0] r_res_rd;

    logic              w_accept;
    logic              w_wb;
    logic [DATA_W-1:0] w_wb_value;
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;

    assign instr_ready = (r_state == IDLE);
    assign res_valid   = (r_state == RESP);
    assign busy        = (r_state != IDLE);

    assign w_accept   = instr_valid && instr_ready;
    assign w_wb       = (r_state == EXEC);
    // LDI bypasses the ALU, which would compute NAND for opcode 11.
    assign w_wb_value = (r_op == OP_LDI) ? r_imm : alu_out;

    assign alu_opcode = r_alu_opcode;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign res_data   = r_res_data;
    assign res_rd     = r_res_rd;

    // Reset clears the file in the same edge, so a pending EXEC write is dropped.
    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_wb),
        .i_waddr   (r_rd),
        .i_wdata   (w_wb_value),
        .i_raddr_a (instr[F_RS1 +: REG_AW]),
        .i_raddr_b (instr[F_RS2 +: REG_AW]),
        .o_rdata_a (w_rs1_data),
        .o_rdata_b (w_rs2_data)
    );

    // Next-state decode.
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next_state = EXEC;
            EXEC:                   w_next_state = RESP;
            RESP:    if (res_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // State, instruction latch, ALU operand drive and write-back capture.
    // NOTE: non-blocking assignments here make every register sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_op         <= OP_XOR;
            r_rd         <= '0;
            r_imm        <= '0;
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_res_data   <= '0;
            r_res_rd     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op         <= op_e'(instr[F_OP +: 2]);
                r_rd         <= instr[F_RD +: REG_AW];
                r_imm        <= instr[DATA_W-1:0];
                r_alu_opcode <= instr[F_OP +: 2];
                r_alu_a      <= w_rs1_data;
                r_alu_b      <= w_rs2_data;
            end
            if (w_wb) begin
                r_res_data <= w_wb_value;
                r_res_rd   <= r_rd;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised and directed bench for alu_sequencer wired to the team ALU.
// Expected values come from an array model of the register file and the
// arithmetic definition of each op.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [ALU_INSTR_W-1:0] instr;
    logic [1:0]             alu_opcode;
    logic [ALU_DATA_W-1:0]  alu_a;
    logic [ALU_DATA_W-1:0]  alu_b;
    logic [ALU_DATA_W-1:0]  alu_out;
    logic                   res_valid;
    logic                   res_ready;
    logic [ALU_DATA_W-1:0]  res_data;
    logic [ALU_REG_AW-1:0]  res_rd;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_rf [4];

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .busy        (busy)
    );

    // Team ALU: combinational, 00 XOR, 01 ADD, 10/11 NAND.
    always_comb begin
        case (alu_opcode)
            2'b00:   alu_out = alu_a ^ alu_b;
            2'b01:   alu_out = alu_a + alu_b;
            default: alu_out = ~(alu_a & alu_b);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] expected_value(input logic [1:0] op, input logic [7:0] a,
                                                  input logic [7:0] b, input logic [7:0] imm);
        int sum;
        case (op)
            2'b00:   return a ^ b;
            2'b01: begin
                sum = (int'(a) + int'(b)) % 256;
                return sum[7:0];
            end
            2'b10:   return ~(a & b);
            default: return imm;
        endcase
    endfunction

    task automatic run_instr(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic [7:0] imm, input int stall);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_v;
        a     = model_rf[rs1];
        b     = model_rf[rs2];
        exp_v = expected_value(op, a, b, imm);

        check("idle_ready", instr_ready, 1);
        check("idle_busy", busy, 0);
        instr       = {op, rd, rs1, rs2, imm};
        instr_valid = 1'b1;
        res_ready   = 1'($urandom_range(0, 1));   // ignored while res_valid is low
        tick;

        instr_valid = 1'b0;
        instr       = 16'($urandom);
        check("exec_ready", instr_ready, 0);
        check("exec_busy", busy, 1);
        check("exec_valid", res_valid, 0);
        check("exec_opcode", alu_opcode, op);
        check("exec_a", alu_a, a);
        check("exec_b", alu_b, b);
        tick;

        check("resp_valid", res_valid, 1);
        check("resp_data", res_data, exp_v);
        check("resp_rd", res_rd, rd);
        model_rf[rd] = exp_v;

        for (int i = 0; i < stall; i++) begin
            res_ready   = 1'b0;
            instr_valid = 1'b1;
            instr       = 16'($urandom);
            tick;
            check("stall_valid", res_valid, 1);
            check("stall_data", res_data, exp_v);
            check("stall_rd", res_rd, rd);
            check("stall_ready", instr_ready, 0);
        end

        instr_valid = 1'b0;
        res_ready   = 1'b1;
        tick;
        res_ready = 1'b0;
        check("post_valid", res_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        res_ready   = 1'b0;
        for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;
        repeat (2) tick;

        check("rst_ready", instr_ready, 1);
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        check("rst_data", res_data, 0);
        check("rst_rd", res_rd, 0);
        rst = 1'b0;
        tick;

        // Directed sequence
        run_instr(OP_LDI,  2'd1, 2'd0, 2'd0, 8'h3C, 0);
        run_instr(OP_LDI,  2'd2, 2'd0, 2'd0, 8'h0F, 0);
        run_instr(OP_XOR,  2'd3, 2'd1, 2'd2, 8'h00, 0);
        check("xor_val", model_rf[3], 8'h33);
        run_instr(OP_ADD,  2'd0, 2'd1, 2'd2, 8'h00, 0);
        check("add_val", model_rf[0], 8'h4B);
        run_instr(OP_NAND, 2'd3, 2'd1, 2'd2, 8'h00, 5);
        check("nand_val", model_rf[3], 8'hF3);
        run_instr(OP_XOR,  2'd0, 2'd3, 2'd3, 8'h00, 0);
        run_instr(OP_LDI,  2'd1, 2'd0, 2'd0, 8'hFF, 0);
        run_instr(OP_LDI,  2'd2, 2'd0, 2'd0, 8'h01, 0);
        run_instr(OP_ADD,  2'd1, 2'd1, 2'd2, 8'h00, 0);
        check("wrap_val", model_rf[1], 8'h00);
        run_instr(OP_ADD,  2'd0, 2'd1, 2'd2, 8'h00, 0);
        check("reuse_val", model_rf[0], 8'h01);

        // Reset during EXEC of ADD r2,r2,r2 drops the write and the response
        instr       = {OP_ADD, 2'd2, 2'd2, 2'd2, 8'h00};
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        check("rexec_busy", busy, 1);
        rst = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;
        check("rexec_valid", res_valid, 0);
        check("rexec_busy0", busy, 0);
        check("rexec_data", res_data, 0);
        check("rexec_a", alu_a, 0);
        rst = 1'b0;
        tick;
        check("rexec_ready", instr_ready, 1);
        check("rexec_valid2", res_valid, 0);
        run_instr(OP_ADD, 2'd3, 2'd2, 2'd0, 8'h00, 0);
        check("rexec_r2", model_rf[3], 8'h00);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            run_instr(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                      8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
